// File: rtl/pc_trace_buffer.sv
// pc_trace_buffer: passive observer of the processor fetch/writeback stream.
// Each new PC is captured with the concurrent writeback value and a sequence
// number into a first-word-fall-through FIFO that drains over valid/ready.
// A capture that finds the FIFO full (with no pop in the same cycle) is dropped
// and counted. The processor is never stalled.
// Optional feature: define PC_TRACE_TIMESTAMP_EN to add a 32-bit cycle counter
// that is stored with every entry and presented on out_time.
module pc_trace_buffer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned PC_W   = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned SEQ_W  = 16
) (
  input  logic                         CLK,
  input  logic                         resetl,
  input  logic                         capture_en,
  input  logic [PC_W-1:0]              currentpc,
  input  logic [DATA_W-1:0]            MemtoRegOut,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_W-1:0]              out_pc,
  output logic [DATA_W-1:0]            out_data,
  output logic [SEQ_W-1:0]             out_seq,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic [SEQ_W-1:0]             overflow_cnt
`ifdef PC_TRACE_TIMESTAMP_EN
  ,
  output logic [31:0]                  out_time
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  // Entry storage
  logic [PC_W-1:0]   pc_mem_q   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [SEQ_W-1:0]  seq_mem_q  [DEPTH];

  // Control state
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PC_W-1:0]   last_pc_q, last_pc_d;
  logic              first_q, first_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [SEQ_W-1:0]  ovf_q, ovf_d;

  // Registered head presentation
  logic              out_valid_q, out_valid_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic [PC_W-1:0]   out_pc_q, out_pc_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SEQ_W-1:0]  out_seq_q, out_seq_d;

  logic request;
  logic push;
  logic pop;
  logic drop;

`ifdef PC_TRACE_TIMESTAMP_EN
  logic [31:0] time_mem_q [DEPTH];
  logic [31:0] time_q, time_d;
  logic [31:0] out_time_q, out_time_d;
`endif

  // Capture decision, pointer/occupancy update and next head selection
  always_comb begin
    request     = capture_en && (first_q || (currentpc != last_pc_q));
    pop         = out_valid_q && out_ready;
    push        = request && (!full_q || pop);
    drop        = request && full_q && !pop;

    last_pc_d   = last_pc_q;
    first_d     = first_q;
    seq_d       = seq_q;
    ovf_d       = ovf_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_pc_d    = out_pc_q;
    out_data_d  = out_data_q;
    out_seq_d   = out_seq_q;
`ifdef PC_TRACE_TIMESTAMP_EN
    time_d      = time_q + 32'(1);
    out_time_d  = out_time_q;
`endif

    if (request) begin
      last_pc_d = currentpc;
      first_d   = 1'b0;
      seq_d     = seq_q + SEQ_W'(1);
    end

    if (drop && (ovf_q != {SEQ_W{1'b1}})) begin
      ovf_d = ovf_q + SEQ_W'(1);
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Next head is either the entry being written now (FIFO was empty, or its
    // only entry is leaving) or an already-stored entry; hold when empty.
    if (count_d != '0) begin
      if (push && (rd_ptr_d == wr_ptr_q)) begin
        out_pc_d   = currentpc;
        out_data_d = MemtoRegOut;
        out_seq_d  = seq_q;
`ifdef PC_TRACE_TIMESTAMP_EN
        out_time_d = time_q;
`endif
      end else begin
        out_pc_d   = pc_mem_q[rd_ptr_d];
        out_data_d = data_mem_q[rd_ptr_d];
        out_seq_d  = seq_mem_q[rd_ptr_d];
`ifdef PC_TRACE_TIMESTAMP_EN
        out_time_d = time_mem_q[rd_ptr_d];
`endif
      end
    end

    out_valid_d = (count_d != '0);
    full_d      = (count_d == CNT_W'(DEPTH));
    empty_d     = (count_d == '0);
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (resetl) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_pc_q   <= '0;
      first_q     <= 1'b1;
      seq_q       <= '0;
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      out_pc_q    <= '0;
      out_data_q  <= '0;
      out_seq_q   <= '0;
`ifdef PC_TRACE_TIMESTAMP_EN
      time_q      <= '0;
      out_time_q  <= '0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      last_pc_q   <= last_pc_d;
      first_q     <= first_d;
      seq_q       <= seq_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      out_pc_q    <= out_pc_d;
      out_data_q  <= out_data_d;
      out_seq_q   <= out_seq_d;
`ifdef PC_TRACE_TIMESTAMP_EN
      time_q      <= time_d;
      out_time_q  <= out_time_d;
`endif
    end
  end

  // Entry write; storage needs no reset since only occupied slots are read
  always_ff @(posedge CLK) begin
    if (!resetl && push) begin
      pc_mem_q[wr_ptr_q]   <= currentpc;
      data_mem_q[wr_ptr_q] <= MemtoRegOut;
      seq_mem_q[wr_ptr_q]  <= seq_q;
`ifdef PC_TRACE_TIMESTAMP_EN
      time_mem_q[wr_ptr_q] <= time_q;
`endif
    end
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = out_pc_q;
  assign out_data     = out_data_q;
  assign out_seq      = out_seq_q;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign overflow_cnt = ovf_q;
`ifdef PC_TRACE_TIMESTAMP_EN
  assign out_time     = out_time_q;
`endif

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Bench for pc_trace_buffer: directed scenarios followed by a random phase,
// every cycle compared against a queue-based reference model.
module tb_pc_trace_buffer;

  localparam int unsigned DEPTH = 16;

  logic        CLK = 1'b0;
  logic        resetl = 1'b1;
  logic        capture_en = 1'b0;
  logic [63:0] currentpc = '0;
  logic [63:0] MemtoRegOut = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [63:0] out_data;
  logic [15:0] out_seq;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic [15:0] overflow_cnt;
`ifdef PC_TRACE_TIMESTAMP_EN
  logic [31:0] out_time;
`endif

  pc_trace_buffer #(.DEPTH(DEPTH), .PC_W(64), .DATA_W(64), .SEQ_W(16)) dut (
    .CLK(CLK), .resetl(resetl), .capture_en(capture_en),
    .currentpc(currentpc), .MemtoRegOut(MemtoRegOut),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_data(out_data), .out_seq(out_seq),
    .count(count), .full(full), .empty(empty), .overflow_cnt(overflow_cnt)
`ifdef PC_TRACE_TIMESTAMP_EN
    , .out_time(out_time)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] data;
    logic [15:0] seq;
    logic [31:0] t;
  } ent_t;

  // Reference model state
  ent_t        q[$];
  logic [63:0] m_last;
  logic        m_first;
  logic [15:0] m_seq;
  logic [15:0] m_ovf;
  logic [31:0] m_time;
  logic [63:0] m_opc, m_odata;
  logic [15:0] m_oseq;
  logic [31:0] m_otime;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("count", 64'(count), 64'(q.size()));
    chk("full", 64'(full), 64'(q.size() == DEPTH));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("overflow_cnt", 64'(overflow_cnt), 64'(m_ovf));
    chk("out_pc", out_pc, m_opc);
    chk("out_data", out_data, m_odata);
    chk("out_seq", 64'(out_seq), 64'(m_oseq));
`ifdef PC_TRACE_TIMESTAMP_EN
    chk("out_time", 64'(out_time), 64'(m_otime));
`endif
  endtask

  // One clock cycle: drive inputs, advance model at the edge, compare after it
  task automatic step(input logic rst, input logic cen, input logic [63:0] pc,
                      input logic [63:0] data, input logic rdy);
    ent_t e;
    bit   pop_m, req_m;
    resetl = rst; capture_en = cen; currentpc = pc; MemtoRegOut = data; out_ready = rdy;
    @(posedge CLK);
    if (rst) begin
      q.delete();
      m_last = '0; m_first = 1'b1; m_seq = '0; m_ovf = '0; m_time = '0;
      m_opc = '0; m_odata = '0; m_oseq = '0; m_otime = '0;
    end else begin
      pop_m = (q.size() != 0) && rdy;
      req_m = cen && (m_first || pc != m_last);
      e.pc = pc; e.data = data; e.seq = m_seq; e.t = m_time;
      if (pop_m) void'(q.pop_front());
      if (req_m) begin
        if (q.size() < DEPTH) q.push_back(e);
        else if (m_ovf != 16'hFFFF) m_ovf++;
        m_last = pc; m_first = 1'b0; m_seq++;
      end
      m_time++;
      if (q.size() != 0) begin
        m_opc = q[0].pc; m_odata = q[0].data; m_oseq = q[0].seq; m_otime = q[0].t;
      end
    end
    #1;
    check_all();
  endtask

  function automatic logic [63:0] dv(input logic [63:0] pc);
    return pc ^ 64'hDEAD_BEEF_0000_0000;
  endfunction

  logic [63:0] last_popped;

  initial begin
    // 1: reset then ramp
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("t1_rst_count", 64'(count), 0);
    chk("t1_rst_empty", 64'(empty), 1);
    chk("t1_rst_outpc", out_pc, 0);
    step(0, 1, 64'h0, dv(64'h0), 0);
    chk("t1_valid_lat", 64'(out_valid), 1);
    step(0, 1, 64'h4, dv(64'h4), 0);
    step(0, 1, 64'h8, dv(64'h8), 0);
    chk("t1_count", 64'(count), 3);
    chk("t1_head_pc", out_pc, 0);
    chk("t1_head_seq", 64'(out_seq), 0);

    // 2: repeat suppression
    for (int i = 0; i < 5; i++) step(0, 1, 64'h40, dv(64'h40), 0);
    chk("t2_count", 64'(count), 4);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    chk("t2_pc", out_pc, 64'h40);
    chk("t2_seq", 64'(out_seq), 3);
    step(0, 0, 0, 0, 1);
    chk("t2_empty", 64'(empty), 1);

    // 3: overflow
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 64'h2000 + 64'(4 * i), dv(64'h2000 + 64'(4 * i)), 0);
    chk("t3_full", 64'(full), 1);
    chk("t3_count", 64'(count), 16);
    chk("t3_ovf", 64'(overflow_cnt), 4);
    for (int i = 0; i < 16; i++) begin
      chk("t3_drain_seq", 64'(out_seq), 64'(i));
      step(0, 0, 0, 0, 1);
    end
    chk("t3_drained", 64'(empty), 1);
    step(0, 1, 64'h3000, dv(64'h3000), 0);
    chk("t3_next_seq", 64'(out_seq), 20);

    // 4: full with simultaneous pop
    for (int i = 0; i < 15; i++) step(0, 1, 64'h3004 + 64'(4 * i), dv(64'h3004 + 64'(4 * i)), 0);
    chk("t4_full", 64'(count), 16);
    step(0, 1, 64'h100, dv(64'h100), 1);
    chk("t4_count", 64'(count), 16);
    chk("t4_ovf", 64'(overflow_cnt), 4);
    last_popped = '0;
    for (int i = 0; i < 16; i++) begin
      last_popped = out_pc;
      step(0, 0, 0, 0, 1);
    end
    chk("t4_last_pc", last_popped, 64'h100);

    // 5: reset mid-operation
    for (int i = 0; i < 5; i++) step(0, 1, 64'h1000 + 64'(4 * i), dv(64'h1000 + 64'(4 * i)), 0);
    step(1, 0, 0, 0, 1);
    chk("t5_valid", 64'(out_valid), 0);
    chk("t5_count", 64'(count), 0);
    chk("t5_ovf", 64'(overflow_cnt), 0);
    step(0, 1, 64'h1E0, dv(64'h1E0), 0);
    chk("t5_seq0", 64'(out_seq), 0);

    // 6: disable while draining, then re-enable
    step(0, 1, 64'h1F0, dv(64'h1F0), 0);
    step(0, 0, 64'h200, dv(64'h200), 1);
    step(0, 0, 64'h204, dv(64'h204), 1);
    chk("t6_drained", 64'(count), 0);
    step(0, 1, 64'h204, dv(64'h204), 0);
    chk("t6_one", 64'(count), 1);
    chk("t6_pc", out_pc, 64'h204);
    step(0, 1, 64'h204, dv(64'h204), 0);
    chk("t6_still_one", 64'(count), 1);

    // Random phase
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 149) == 0),
           ($urandom_range(0, 3) != 0),
           64'($urandom_range(0, 7)) << 2,
           {32'($urandom), 32'($urandom)},
           ($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
